// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/AND/OR/SLL/SRA, iterative MUL/DIV.
// Signed operands; flags and result are registered and held between pulses.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               is_not_equal,
  output logic               is_less_than,
  output logic               mult_exception,
  output logic               div_exception,
  output logic               illegal_op
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_e;

  localparam int            CW   = SHAMT_W + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic             divz_q, divz_d;
  logic             pne_q, pne_d;
  logic             plt_q, plt_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ne_q, ne_d;
  logic             lt_q, lt_d;
  logic             mx_q, mx_d;
  logic             dx_q, dx_d;
  logic             il_q, il_d;

  logic [WIDTH-1:0] a_mag, b_mag, alu_res;
  logic             a_ne, a_lt, illegal;

  assign a_mag   = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign b_mag   = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign a_ne    = operand_a != operand_b;
  assign a_lt    = $signed(operand_a) < $signed(operand_b);
  assign illegal = opcode[4] | opcode[3];

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = operand_a + operand_b;
      OP_SUB:  alu_res = operand_a - operand_b;
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_SLL:  alu_res = operand_a << shamt;
      OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step on magnitudes: {hi,lo} ends as the unsigned product
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   mhi_n, mlo_n;
  logic [2*WIDTH-1:0] prod;
  logic               mul_ovf;

  assign msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign mhi_n   = msum[WIDTH:1];
  assign mlo_n   = {msum[0], lo_q[WIDTH-1:1]};
  assign prod    = neg_q ? -{mhi_n, mlo_n} : {mhi_n, mlo_n};
  assign mul_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};

  // Restoring divide: hi holds remainder, lo shifts dividend into quotient
  logic [WIDTH:0]   dsh, dtr;
  logic [WIDTH-1:0] dhi_n, dlo_n, quo;

  assign dsh   = {hi_q, lo_q[WIDTH-1]};
  assign dtr   = dsh - {1'b0, m_q};
  assign dhi_n = dtr[WIDTH] ? dsh[WIDTH-1:0] : dtr[WIDTH-1:0];
  assign dlo_n = {lo_q[WIDTH-2:0], ~dtr[WIDTH]};
  assign quo   = neg_q ? -dlo_n : dlo_n;

  assign in_ready = state_q == IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    neg_d   = neg_q;
    divz_d  = divz_q;
    pne_d   = pne_q;
    plt_d   = plt_q;
    ov_d    = 1'b0;
    res_d   = res_q;
    ne_d    = ne_q;
    lt_d    = lt_q;
    mx_d    = mx_q;
    dx_d    = dx_q;
    il_d    = il_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_d  = '0;
            hi_d   = '0;
            neg_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            divz_d = operand_b == '0;
            pne_d  = a_ne;
            plt_d  = a_lt;
            if (opcode == OP_MUL) begin
              state_d = MUL_RUN;
              lo_d    = b_mag;
              m_d     = a_mag;
            end else if (opcode == OP_DIV) begin
              state_d = DIV_RUN;
              lo_d    = a_mag;
              m_d     = b_mag;
            end else begin
              ov_d  = 1'b1;
              res_d = alu_res;
              ne_d  = a_ne & ~illegal;
              lt_d  = a_lt & ~illegal;
              mx_d  = 1'b0;
              dx_d  = 1'b0;
              il_d  = illegal;
            end
          end
        end
        MUL_RUN: begin
          hi_d  = mhi_n;
          lo_d  = mlo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b1;
            res_d   = prod[WIDTH-1:0];
            ne_d    = pne_q;
            lt_d    = plt_q;
            mx_d    = mul_ovf;
            dx_d    = 1'b0;
            il_d    = 1'b0;
          end
        end
        DIV_RUN: begin
          hi_d  = dhi_n;
          lo_d  = dlo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b1;
            res_d   = divz_q ? '0 : quo;
            ne_d    = pne_q;
            lt_d    = plt_q;
            mx_d    = 1'b0;
            dx_d    = divz_q;
            il_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
      pne_q   <= 1'b0;
      plt_q   <= 1'b0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      ne_q    <= 1'b0;
      lt_q    <= 1'b0;
      mx_q    <= 1'b0;
      dx_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
      pne_q   <= pne_d;
      plt_q   <= plt_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      ne_q    <= ne_d;
      lt_q    <= lt_d;
      mx_q    <= mx_d;
      dx_q    <= dx_d;
      il_q    <= il_d;
    end
  end

  assign out_valid      = ov_q;
  assign result         = res_q;
  assign is_not_equal   = ne_q;
  assign is_less_than   = lt_q;
  assign mult_exception = mx_q;
  assign div_exception  = dx_q;
  assign illegal_op     = il_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: per-cycle arithmetic model plus directed
// vectors with literal expectations.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n, in_valid, in_ready, flush, out_valid;
  logic [4:0]   opcode, shamt;
  logic [W-1:0] operand_a, operand_b, result;
  logic         is_not_equal, is_less_than;
  logic         mult_exception, div_exception, illegal_op;

  int total = 0;
  int bad   = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .shamt(shamt), .flush(flush),
    .out_valid(out_valid), .result(result),
    .is_not_equal(is_not_equal), .is_less_than(is_less_than),
    .mult_exception(mult_exception), .div_exception(div_exception),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // flags packed as {ne, lt, mult_exc, div_exc, illegal}
  function automatic void golden(input logic [4:0] op,
                                 input logic [W-1:0] a, b,
                                 input logic [4:0] sh,
                                 output logic [W-1:0] r,
                                 output logic [4:0] f);
    int     sa, sb;
    longint p;
    logic   ne, lt, mx, dx, il;
    sa = a;
    sb = b;
    ne = a != b;
    lt = sa < sb;
    mx = 0; dx = 0; il = 0;
    r  = '0;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = sa >>> sh;
      5'd6: begin
        p  = longint'(sa) * longint'(sb);
        r  = p[31:0];
        mx = p != longint'(int'(r));
      end
      5'd7: begin
        if (b == 0) begin r = 0; dx = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = sa / sb;
      end
      default: begin r = 0; il = 1; ne = 0; lt = 0; end
    endcase
    f = {ne, lt, mx, dx, il};
  endfunction

  int           m_busy = 0;
  bit           m_ov   = 0;
  logic [W-1:0] m_res  = '0, p_res = '0, g_r;
  logic [4:0]   m_fl   = '0, p_fl  = '0, g_f;

  // Model advances on what the DUT saw at the preceding rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_busy = 0; m_ov = 0; m_res = '0; m_fl = '0;
    end else begin
      m_ov = 0;
      if (flush) m_busy = 0;
      else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_ov = 1; m_res = p_res; m_fl = p_fl; end
      end else if (in_valid) begin
        golden(opcode, operand_a, operand_b, shamt, g_r, g_f);
        if (opcode == 5'd6 || opcode == 5'd7) begin
          m_busy = W; p_res = g_r; p_fl = g_f;
        end else begin
          m_ov = 1; m_res = g_r; m_fl = g_f;
        end
      end
    end
    chk("m_out_valid", out_valid, m_ov);
    chk("m_in_ready", in_ready, m_busy == 0);
    chk("m_result", result, m_res);
    chk("m_flags", {is_not_equal, is_less_than, mult_exception,
                    div_exception, illegal_op}, m_fl);
  end

  task automatic put(input logic [4:0] op, input logic [W-1:0] a, b,
                     input logic [4:0] sh);
    @(negedge clock); #1;
    in_valid = 1; opcode = op; operand_a = a; operand_b = b; shamt = sh;
  endtask

  task automatic wait_out(output int n, output int rdy_hi);
    n = 0; rdy_hi = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      n++;
      if (n == 1) begin #1; in_valid = 0; end
      if (out_valid) break;
      if (in_ready) rdy_hi++;
    end
    chk("timeout", out_valid, 1);
  endtask

  function automatic logic [4:0] flags();
    return {is_not_equal, is_less_than, mult_exception,
            div_exception, illegal_op};
  endfunction

  int n, rh;

  initial begin
    reset_n = 0; in_valid = 0; flush = 0; opcode = 0;
    operand_a = 0; operand_b = 0; shamt = 0;
    repeat (3) @(negedge clock);
    chk("rst_result", result, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    #1 reset_n = 1;

    put(5'd0, 32'h7FFF_FFFF, 32'h1, 0);
    wait_out(n, rh);
    chk("add_lat", n, 1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_flags", flags(), 5'b10000);

    put(5'd1, 32'hFFFF_FFFB, 32'd3, 0);
    @(negedge clock);
    chk("sub_ov", out_valid, 1);
    chk("sub_res", result, 32'hFFFF_FFF8);
    chk("sub_lt", is_less_than, 1);
    #1; opcode = 5'd5; operand_a = 32'h8000_0000; operand_b = 0; shamt = 4;
    @(negedge clock);
    chk("sra_ov", out_valid, 1);
    chk("sra_res", result, 32'hF800_0000);
    #1 in_valid = 0;

    put(5'd6, 32'hFFFF_FFF9, 32'd6, 0);
    wait_out(n, rh);
    chk("mul_lat", n, 33);
    chk("mul_res", result, 32'hFFFF_FFD6);
    chk("mul_exc", mult_exception, 0);

    put(5'd6, 32'h0001_0000, 32'h0001_0000, 0);
    wait_out(n, rh);
    chk("mulov_res", result, 0);
    chk("mulov_exc", mult_exception, 1);

    put(5'd7, 32'hFFFF_FF9C, 32'd7, 0);
    wait_out(n, rh);
    chk("div_lat", n, 33);
    chk("div_rdy", rh, 0);
    chk("div_res", result, 32'hFFFF_FFF2);

    put(5'd7, 32'd100, 32'd0, 0);
    wait_out(n, rh);
    chk("div0_lat", n, 33);
    chk("div0_rdy", rh, 0);
    chk("div0_res", result, 0);
    chk("div0_exc", div_exception, 1);

    put(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_out(n, rh);
    chk("divmin_res", result, 32'h8000_0000);
    chk("divmin_exc", div_exception, 0);

    put(5'd13, 32'd5, 32'd5, 0);
    wait_out(n, rh);
    chk("ill_lat", n, 1);
    chk("ill_res", result, 0);
    chk("ill_flag", illegal_op, 1);

    put(5'd7, 32'd1000, 32'd3, 0);
    @(negedge clock); #1 in_valid = 0;
    repeat (9) @(negedge clock);
    #1; flush = 1; in_valid = 1; opcode = 5'd0; operand_a = 1; operand_b = 1;
    @(negedge clock);
    chk("flush_ov", out_valid, 0);
    chk("flush_rdy", in_ready, 1);
    #1; flush = 0; in_valid = 0;
    repeat (40) @(negedge clock);

    #1; flush = 1; in_valid = 1;
    @(negedge clock);
    chk("flush_idle_ov", out_valid, 0);
    #1; flush = 0; in_valid = 0;

    put(5'd6, 32'd3, 32'd5, 0);
    @(negedge clock); #1 in_valid = 0;
    repeat (5) @(negedge clock);
    #1 reset_n = 0;
    @(negedge clock);
    chk("rstmid_ov", out_valid, 0);
    chk("rstmid_res", result, 0);
    chk("rstmid_rdy", in_ready, 1);
    #1; reset_n = 1; in_valid = 1; opcode = 5'd0;
    operand_a = 32'd2; operand_b = 32'd2; shamt = 0;
    wait_out(n, rh);
    chk("post_rst_lat", n, 1);
    chk("post_rst_res", result, 32'd4);
    repeat (40) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
